// File: rtl/pool_pkg.sv
// Shared types and helpers for the streaming max-pool controller.
package pool_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Widest pixel the signed compare helper handles; callers sign-extend into it.
  localparam int MAX_W = 64;

  function automatic int out_size(input int in_size, input int pool);
    return in_size / pool;
  endfunction

  function automatic int edge_len(input int in_size, input int pool);
    return (in_size / pool) * pool;
  endfunction

  function automatic logic signed [MAX_W-1:0] smax(input logic signed [MAX_W-1:0] a,
                                                   input logic signed [MAX_W-1:0] b);
    return (b > a) ? b : a;
  endfunction

endpackage

// File: rtl/pool_acc_bank.sv
// Per-output-column running-max accumulators; exposes the value a write would store.
module pool_acc_bank
  import pool_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int K_W    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              load,
  input  logic [K_W-1:0]    k,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] merged
);

  // Entries past the last full window column exist only so k indexes exactly; they are never written.
  localparam int ENTRIES = 2 ** K_W;

  logic [DATA_W-1:0] acc_r [ENTRIES];

  // First pixel of a window loads, later pixels fold in with a signed max.
  always_comb begin
    merged = din;
    if (load) begin
      merged = din;
    end else begin
      merged = DATA_W'(smax(MAX_W'(signed'(acc_r[k])), MAX_W'(signed'(din))));
    end
  end

  // Accumulator storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        acc_r[i] <= '0;
      end
    end else if (wr_en) begin
      acc_r[k] <= merged;
    end
  end

endmodule

// File: rtl/pool_stream_ctrl.sv
// Streaming max-pool sequencer: raster pixels in, raster pooled maxima out, one frame per start.
module pool_stream_ctrl
  import pool_pkg::*;
#(
  parameter int INPUT_SIZE = 8,
  parameter int POOL_SIZE  = 2,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int OUT_SIZE = out_size(INPUT_SIZE, POOL_SIZE);
  localparam int TOTAL    = INPUT_SIZE * INPUT_SIZE;
  localparam int C_W      = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam int P_W      = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
  localparam int K_W      = $clog2(OUT_SIZE + 1);
  localparam int N_W      = $clog2(TOTAL + 1);

  localparam logic [C_W-1:0] C_LAST  = C_W'(INPUT_SIZE - 1);
  localparam logic [P_W-1:0] P_LAST  = P_W'(POOL_SIZE - 1);
  localparam logic [K_W-1:0] K_LIM   = K_W'(OUT_SIZE);
  localparam logic [K_W-1:0] K_LAST  = K_W'(OUT_SIZE - 1);
  localparam logic [N_W-1:0] N_TOTAL = N_W'(TOTAL);

  state_e            state_r, state_nx_s;
  logic [C_W-1:0]    c_r;
  logic [P_W-1:0]    pr_r, pc_r;
  logic [K_W-1:0]    kr_r, kc_r;
  logic [N_W-1:0]    cnt_r;
  logic              out_valid_r, out_last_r;
  logic [DATA_W-1:0] out_data_r, merged_s;
  logic              all_in_s, accept_s, in_edge_s, win_first_s, win_end_s, frame_last_s;

  // Window position is tracked as block index (kr/kc) plus offset inside the block (pr/pc).
  assign all_in_s     = (cnt_r == N_TOTAL);
  assign in_ready     = (state_r == RUN) && !all_in_s && (!out_valid_r || out_ready);
  assign accept_s     = in_valid && in_ready;
  assign in_edge_s    = (kr_r < K_LIM) && (kc_r < K_LIM);
  assign win_first_s  = (pr_r == '0) && (pc_r == '0);
  assign win_end_s    = (pr_r == P_LAST) && (pc_r == P_LAST);
  assign frame_last_s = (kr_r == K_LAST) && (kc_r == K_LAST);

  assign busy      = (state_r == RUN);
  assign done      = (state_r == DONE);
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;

  pool_acc_bank #(
    .DATA_W (DATA_W),
    .K_W    (K_W)
  ) u_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (accept_s && in_edge_s),
    .load   (win_first_s),
    .k      (kc_r),
    .din    (in_data),
    .merged (merged_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state: the frame ends once every pixel is in and no result is left pending.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx_s = RUN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (all_in_s && (!out_valid_r || out_ready)) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = RUN;
        end
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Raster position counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_r <= '0; pr_r <= '0; pc_r <= '0; kr_r <= '0; kc_r <= '0; cnt_r <= '0;
    end else if ((state_r == IDLE) && start) begin
      c_r <= '0; pr_r <= '0; pc_r <= '0; kr_r <= '0; kc_r <= '0; cnt_r <= '0;
    end else if (accept_s) begin
      cnt_r <= cnt_r + N_W'(1);
      if (c_r == C_LAST) begin
        c_r  <= '0;
        pc_r <= '0;
        kc_r <= '0;
        pr_r <= (pr_r == P_LAST) ? '0 : pr_r + P_W'(1);
        if (pr_r == P_LAST) begin
          kr_r <= kr_r + K_W'(1);
        end
      end else begin
        c_r  <= c_r + C_W'(1);
        pc_r <= (pc_r == P_LAST) ? '0 : pc_r + P_W'(1);
        if (pc_r == P_LAST) begin
          kc_r <= kc_r + K_W'(1);
        end
      end
    end
  end

  // Result register: a completing window may replace a result handshaking this same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_last_r  <= 1'b0;
    end else if (accept_s && in_edge_s && win_end_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= merged_s;
      out_last_r  <= frame_last_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pool_stream_ctrl.sv
// Directed bench: a 4x4 and a 5x5 instance (P=2) driven by hand-computed frames.
module tb_pool_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start4 = 1'b0, start5 = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] in_data = '0;
  logic        busy4, done4, in_ready4, out_valid4, out_last4;
  logic        busy5, done5, in_ready5, out_valid5, out_last5;
  logic [31:0] out_data4, out_data5;
  logic        sel = 1'b0;
  logic        o_busy, o_done, o_in_ready, o_out_valid, o_out_last;
  logic [31:0] o_out_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_q[$];
  int res_data[$];
  bit res_last[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pool_stream_ctrl #(.INPUT_SIZE(4), .POOL_SIZE(2), .DATA_W(32)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .busy(busy4), .done(done4),
    .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4), .out_last(out_last4)
  );

  pool_stream_ctrl #(.INPUT_SIZE(5), .POOL_SIZE(2), .DATA_W(32)) u5 (
    .clk(clk), .rst_n(rst_n), .start(start5), .busy(busy5), .done(done5),
    .in_valid(in_valid), .in_ready(in_ready5), .in_data(in_data),
    .out_valid(out_valid5), .out_ready(out_ready), .out_data(out_data5), .out_last(out_last5)
  );

  always_comb begin
    if (sel) begin
      o_busy = busy5; o_done = done5; o_in_ready = in_ready5;
      o_out_valid = out_valid5; o_out_data = out_data5; o_out_last = out_last5;
    end else begin
      o_busy = busy4; o_done = done4; o_in_ready = in_ready4;
      o_out_valid = out_valid4; o_out_data = out_data4; o_out_last = out_last4;
    end
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pixval(input int idx, input bit neg);
    int v;
    v = neg ? -(idx + 1) : idx;
    return v;
  endfunction

  // Runs one frame on the selected instance and checks results against exp_q.
  task automatic run_frame(input bit use5, input int side, input bit neg, input int stall,
                           input bit rnd, input bit restart, input int done_gap);
    int idx, n, stall_left, done_cnt, done_cyc, last_hs_cyc, last_acc_cyc;
    bit first_seen;
    n = side * side; idx = 0; stall_left = 0; first_seen = 1'b0;
    done_cnt = 0; done_cyc = -1; last_hs_cyc = -1; last_acc_cyc = -1;
    res_data.delete(); res_last.delete();
    sel = use5;
    @(posedge clk); #1;
    start4 = !use5; start5 = use5;
    @(posedge clk); #1;
    start4 = 1'b0; start5 = 1'b0;
    chk("busy_after_start", o_busy, 1);
    for (int b = 0; b < 400; b++) begin
      in_valid = (idx < n) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
      in_data  = pixval(idx, neg);
      if (stall > 0 && !first_seen && o_out_valid) begin
        first_seen = 1'b1;
        stall_left = stall;
      end
      out_ready = (stall_left == 0);
      start4 = restart && (idx == 5) && !use5;
      start5 = restart && (idx == 5) && use5;
      @(negedge clk);
      if (stall_left > 0) begin
        chk("stall_in_ready", o_in_ready, 0);
        chk("stall_hold", $signed(o_out_data), exp_q[0]);
        stall_left--;
      end
      if (o_out_valid && out_ready) begin
        res_data.push_back($signed(o_out_data));
        res_last.push_back(o_out_last);
        if (o_out_last) last_hs_cyc = cyc;
      end
      if (in_valid && o_in_ready) begin
        idx++;
        last_acc_cyc = cyc;
      end
      if (o_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      @(posedge clk); #1;
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
    end
    in_valid = 1'b0; out_ready = 1'b1; start4 = 1'b0; start5 = 1'b0;
    chk("done_seen", done_cyc >= 0, 1);
    chk("done_width", done_cnt, 1);
    chk("pixels_accepted", idx, n);
    chk("result_count", res_data.size(), exp_q.size());
    for (int i = 0; i < res_data.size() && i < exp_q.size(); i++) begin
      chk("result_data", res_data[i], exp_q[i]);
      chk("result_last", res_last[i], (i == exp_q.size() - 1));
    end
    if (done_gap > 0) chk("done_after_handshake", done_cyc - last_hs_cyc, done_gap);
    if (done_gap < 0) chk("done_after_accept", done_cyc - last_acc_cyc, -done_gap);
    chk("busy_after_done", o_busy, 0);
  endtask

  initial begin
    int acc;
    #2;
    chk("rst_busy", busy4, 0);
    chk("rst_done", done4, 0);
    chk("rst_in_ready", in_ready4, 0);
    chk("rst_out_valid", out_valid4, 0);
    chk("rst_out_last", out_last4, 0);
    chk("rst_out_data", out_data4, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    exp_q = '{5, 7, 13, 15};
    run_frame(1'b0, 4, 1'b0, 0, 1'b0, 1'b0, 1);

    exp_q = '{-1, -3, -9, -11};
    run_frame(1'b0, 4, 1'b1, 0, 1'b0, 1'b0, 0);

    exp_q = '{5, 7, 13, 15};
    run_frame(1'b0, 4, 1'b0, 5, 1'b0, 1'b0, 0);

    exp_q = '{6, 8, 16, 18};
    run_frame(1'b1, 5, 1'b0, 0, 1'b0, 1'b0, -2);

    // Reset mid-frame after six pixels, with result 5 pending.
    sel = 1'b0;
    @(posedge clk); #1; start4 = 1'b1;
    @(posedge clk); #1; start4 = 1'b0;
    acc = 0;
    for (int i = 0; i < 40 && acc < 6; i++) begin
      in_valid = 1'b1; in_data = acc; out_ready = 1'b1;
      @(negedge clk);
      if (o_in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("pre_reset_accepts", acc, 6);
    chk("pre_reset_valid", o_out_valid, 1);
    chk("pre_reset_data", o_out_data, 5);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", o_busy, 0);
    chk("midrst_done", o_done, 0);
    chk("midrst_in_ready", o_in_ready, 0);
    chk("midrst_out_valid", o_out_valid, 0);
    chk("midrst_out_last", o_out_last, 0);
    chk("midrst_out_data", o_out_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q = '{5, 7, 13, 15};
    run_frame(1'b0, 4, 1'b0, 0, 1'b0, 1'b0, 0);

    // Repeated start during RUN with random in_valid.
    run_frame(1'b0, 4, 1'b0, 0, 1'b1, 1'b1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pool_stream_ctrl.md
Name: pool_stream_ctrl

Overview:
Streaming sequencer for max pooling on one feature-map channel. Pixels arrive one per beat in raster order (row-major) over a valid/ready input. A bank of per-output-column running-max accumulators folds each POOL_SIZE x POOL_SIZE window. The block emits pooled results in raster order over a valid/ready output. It is the time-multiplexed replacement for the fully parallel pooling array and sits between the convolution output stream and the next layer's input buffer.

Parameters:
INPUT_SIZE, 8, feature-map side length in pixels (>= POOL_SIZE)
POOL_SIZE, 2, pooling window side length, stride = POOL_SIZE (>= 1)
DATA_W, 32, pixel width, signed two's complement

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse that begins one frame; honoured only in IDLE
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse when the frame is complete
in_valid  input  1  input pixel valid
in_ready  output  1  block can accept a pixel
in_data  input  DATA_W  input pixel
out_valid  output  1  pooled result valid
out_ready  input  1  downstream accepts the result
out_data  output  DATA_W  pooled maximum
out_last  output  1  qualifies the final pooled result of the frame

Behaviour:
- Derived values: OUT_SIZE = INPUT_SIZE/POOL_SIZE (floor) and EDGE = OUT_SIZE*POOL_SIZE.
- Reset: state=IDLE; busy, done, out_valid, out_last, in_ready = 0; out_data = 0; all counters and accumulators = 0.
- FSM states:
  - IDLE: start moves to RUN.
  - RUN: accepts exactly INPUT_SIZE*INPUT_SIZE pixels. Moves to DONE once all pixels are accepted and out_valid=0, or in the cycle the final output handshake completes.
  - DONE: done=1 for one cycle, then IDLE.
- busy = (state==RUN).
- start outside IDLE is ignored.
- in_ready = (state==RUN) && pixels_remaining && (!out_valid || out_ready). A pixel is accepted when in_valid && in_ready.
- Counters: row r and column c. On each accepted pixel, c increments; when c wraps at INPUT_SIZE-1 it returns to 0 and r increments.
- Accumulator update for an accepted pixel (r,c) with r<EDGE and c<EDGE, using k = c/POOL_SIZE:
  - If r%P==0 and c%P==0, acc[k] is set to in_data.
  - Otherwise acc[k] is set to smax(acc[k], in_data), a signed compare.
- Emitting a result: if the accepted pixel has r%P==P-1 and c%P==P-1:
  - The next cycle has out_valid=1 and out_data = smax(acc[k], in_data), or in_data when P==1.
  - out_last=1 if r==EDGE-1 and c==EDGE-1.
- Truncated region: pixels with r>=EDGE or c>=EDGE are accepted and discarded. They do not touch the accumulators.
- Latency: out_valid is asserted 1 cycle after the window's last pixel is accepted.
- Output holding: out_valid, out_data and out_last hold stable until out_ready.
- Same-cycle handshake: when out_ready is high and a new window completes in the same cycle, out_valid stays 1 and the data is replaced. Otherwise out_valid clears on the handshake.
- No pixel is lost or duplicated under any in_valid/out_ready pattern.
- Ties: equal values give the same result whichever operand is selected.
- Reset asserted mid-frame: immediately returns to reset values and any partial frame is discarded.

Decomposition:
- Package pool_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the localparam function for OUT_SIZE/EDGE;
  - the signed smax function.
- One sub-module is natural: pool_acc_bank, the OUT_SIZE-entry accumulator array with load/update/read by index k. Counters, FSM and handshake stay in the top.

Test Plan:
- 4x4, P=2, in_data=0..15 streamed with in_valid always high and out_ready=1. Required outputs: 5, 7, 13, 15, with out_last on 15. done pulses one cycle after the final handshake.
- 4x4, P=2, in_data = -(i+1) for i=0..15. Required outputs: -1, -3, -9, -11, which checks the signed compare.
- 4x4, P=2, values 0..15 with out_ready held low for 5 cycles after the first out_valid. Required: in_ready=0 while stalled, out_data holds 5, and all 4 results arrive intact and in order.
- 5x5, P=2, values 0..24. Required outputs: 6, 8, 16, 18, with out_last on 18. Pixels 19..24 are accepted and dropped, and done follows acceptance of pixel 24.
- rst_n pulsed low after 6 pixels of a 4x4 frame. Required: all outputs return to reset values at once. A fresh start with 0..15 then produces 5, 7, 13, 15.
- start pulsed again during RUN, and in_valid toggled randomly. Required: the second start is ignored and the result sequence is unchanged.
